// File: rtl/prio_enc_8x3.sv
// 8-line request accumulator with a fixed or round-robin priority encoder and a
// valid/ready presentation stage; one grant per cycle when the consumer keeps up.
module prio_enc_8x3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       en,
  input  logic       rr,
  input  logic       out_ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       dup
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state;
  logic [2:0] last;
  logic       grant;
  logic [2:0] sel;
  logic [7:0] clear;

  function automatic logic [2:0] sel_fixed(input logic [7:0] p);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++)
      if (p[i]) s = 3'(i);
    return s;
  endfunction

  // Walk from the lowest-priority slot (last itself) up to last-1; later hits
  // overwrite earlier ones, so the line nearest below last wins.
  function automatic logic [2:0] sel_rr(input logic [7:0] p, input logic [2:0] lst);
    logic [2:0] s;
    logic [2:0] idx;
    s = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = lst - 3'(k);
      if (p[idx]) s = idx;
    end
    return s;
  endfunction

  always_comb begin
    grant = en && (pending != 8'h00) && ((state == IDLE) || out_ready);
    sel   = rr ? sel_rr(pending, last) : sel_fixed(pending);
    clear = grant ? (8'h01 << sel) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= 1'b0;
      code    <= 3'd0;
      pending <= 8'h00;
      dup     <= 1'b0;
      last    <= 3'd0;
    end else begin
      pending <= (pending & ~clear) | req;
      dup     <= |(req & pending & ~clear);
      if (grant) begin
        code  <= sel;
        last  <= sel;
        state <= PRESENT;
        valid <= 1'b1;
      end else if ((state == PRESENT) && out_ready) begin
        state <= IDLE;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_8x3.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_prio_enc_8x3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       en = 1'b0;
  logic       rr = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       dup;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_pend[8];
  int m_valid, m_code, m_last, m_dup;

  prio_enc_8x3 dut (
    .clk(clk), .rst(rst), .req(req), .en(en), .rr(rr), .out_ready(out_ready),
    .code(code), .valid(valid), .pending(pending), .dup(dup)
  );

  always #5 clk = ~clk;

  function automatic int m_pend_val();
    int v = 0;
    for (int i = 0; i < 8; i++) v += m_pend[i] * (1 << i);
    return v;
  endfunction

  // One clock: the model advances from the same inputs the DUT samples.
  task automatic step();
    int any, g, pick, clr;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 0;
      m_valid = 0; m_code = 0; m_last = 0; m_dup = 0;
    end else begin
      any = 0;
      for (int i = 0; i < 8; i++) any |= m_pend[i];
      g = en && any && (!m_valid || out_ready);
      pick = -1;
      if (g) begin
        if (rr) begin
          for (int d = 1; d <= 8 && pick < 0; d++)
            if (m_pend[(m_last + 8 - d) % 8]) pick = (m_last + 8 - d) % 8;
        end else begin
          for (int i = 7; i >= 0 && pick < 0; i--)
            if (m_pend[i]) pick = i;
        end
      end
      m_dup = 0;
      for (int i = 0; i < 8; i++) begin
        clr = (i == pick);
        if (req[i] && m_pend[i] && !clr) m_dup = 1;
        m_pend[i] = (m_pend[i] && !clr) || req[i];
      end
      if (g) begin
        m_code = pick; m_last = pick; m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hA5; en = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; req = 8'h00;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if ({valid, code, pending, dup} !== 13'd0) begin
        bad++;
        $display("FAIL reset_idle c%0d: got v=%0d code=%0d pend=%02h dup=%0d want all zero",
                 c, valid, code, pending, dup);
      end
    end
  endtask

  task automatic test_fixed();
    int exp_code[3] = '{7, 2, 0};
    rr = 1'b0; en = 1'b1; out_ready = 1'b1;
    req = 8'b1000_0101;
    step();
    req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (valid !== 1'b1 || code !== 3'(exp_code[c])) begin
        bad++;
        $display("FAIL fixed_seq c%0d: got v=%0d code=%0d want v=1 code=%0d",
                 c, valid, code, exp_code[c]);
      end
    end
    step();
    total++;
    if (valid !== 1'b0 || pending !== 8'h00 || code !== 3'd0) begin
      bad++;
      $display("FAIL fixed_drain: got v=%0d pend=%02h code=%0d want v=0 pend=00 code=0",
               valid, pending, code);
    end
  endtask

  task automatic test_hold();
    rr = 1'b0; en = 1'b1; out_ready = 1'b0;
    req = 8'h10;
    step();
    req = 8'h00;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (valid !== 1'b1 || code !== 3'd4) begin
        bad++;
        $display("FAIL hold c%0d: got v=%0d code=%0d want v=1 code=4", c, valid, code);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (valid !== 1'b0 || code !== 3'd4) begin
      bad++;
      $display("FAIL hold_release: got v=%0d code=%0d want v=0 code=4", valid, code);
    end
  endtask

  task automatic test_rr();
    int exp_code[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rst = 1'b1; step(); rst = 1'b0;
    rr = 1'b1; en = 1'b1; out_ready = 1'b1; req = 8'hFF;
    step();
    for (int c = 0; c < 9; c++) begin
      step();
      total++;
      if (valid !== 1'b1 || code !== 3'(exp_code[c]) || dup !== 1'b1 || pending !== 8'hFF) begin
        bad++;
        $display("FAIL rr_seq c%0d: got v=%0d code=%0d dup=%0d pend=%02h want v=1 code=%0d dup=1 pend=ff",
                 c, valid, code, dup, pending, exp_code[c]);
      end
    end
    req = 8'h00; rr = 1'b0;
    for (int c = 0; c < 10; c++) step();
  endtask

  task automatic test_enable();
    rst = 1'b1; step(); rst = 1'b0;
    rr = 1'b0; en = 1'b0; out_ready = 1'b1; req = 8'h03;
    step();
    req = 8'h00;
    step();
    total++;
    if (pending !== 8'h03 || valid !== 1'b0) begin
      bad++;
      $display("FAIL en_block: got pend=%02h v=%0d want pend=03 v=0", pending, valid);
    end
    en = 1'b1;
    step();
    total++;
    if (valid !== 1'b1 || code !== 3'd1) begin
      bad++;
      $display("FAIL en_grant1: got v=%0d code=%0d want v=1 code=1", valid, code);
    end
    step();
    total++;
    if (valid !== 1'b1 || code !== 3'd0 || pending !== 8'h00) begin
      bad++;
      $display("FAIL en_grant0: got v=%0d code=%0d pend=%02h want v=1 code=0 pend=00",
               valid, code, pending);
    end
    step();
  endtask

  task automatic test_reset_mid();
    rr = 1'b0; en = 1'b1; out_ready = 1'b0; req = 8'h1C;
    step();
    req = 8'h00;
    step();
    total++;
    if (valid !== 1'b1 || code !== 3'd4 || pending !== 8'h0C) begin
      bad++;
      $display("FAIL mid_setup: got v=%0d code=%0d pend=%02h want v=1 code=4 pend=0c",
               valid, code, pending);
    end
    rst = 1'b1; req = 8'hFF;
    step();
    rst = 1'b0; req = 8'h00;
    total++;
    if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00 || dup !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got v=%0d code=%0d pend=%02h dup=%0d want all zero",
               valid, code, pending, dup);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      en = ($urandom_range(0, 4) != 0);
      rr = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      total++;
      if (valid !== 1'(m_valid) || code !== 3'(m_code) ||
          pending !== 8'(m_pend_val()) || dup !== 1'(m_dup)) begin
        bad++;
        $display("FAIL random c%0d: got v=%0d code=%0d pend=%02h dup=%0d want v=%0d code=%0d pend=%02h dup=%0d",
                 c, valid, code, pending, dup, m_valid, m_code, m_pend_val(), m_dup);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
    m_valid = 0; m_code = 0; m_last = 0; m_dup = 0;
    test_reset();
    test_fixed();
    test_hold();
    test_rr();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_enc_8x3.md
PRIO_ENC_8X3 -- requirements
Module: prio_enc_8x3

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request bits, one per line; a high bit marks that line requested in the cycle sampled.
- en  input  1  enables new selections; low freezes selection, not handshake.
- rr  input  1  0 = fixed priority, 1 = round-robin priority.
- out_ready  input  1  consumer accepts code when high with valid.
- code  output  3  encoded index of the granted line, registered.
- valid  output  1  code is presented, registered.
- pending  output  8  accumulated, not-yet-granted requests, registered.
- dup  output  1  one-cycle pulse: a request hit an already-pending line.
REQ-002 SHALL have no parameters; widths are fixed at 8 lines and 3-bit code.

Function
REQ-003 SHALL OR req into pending every cycle: pending_next = (pending & ~clear) | req, where clear is the one-hot of the line granted this cycle.
REQ-004 SHALL give set priority over clear: a req bit on the line being granted in the same cycle stays pending.
REQ-005 SHALL drive dup high for exactly the cycle after any req bit arrives on a line already pending (after clear); dup does not block accumulation.
REQ-006 SHALL implement a two-state FSM: IDLE (valid=0), PRESENT (valid=1).
REQ-007 In IDLE with en=1 and pending!=0, SHALL grant one line: load code, clear its pending bit, go to PRESENT; valid rises one cycle after the pending bit is visible.
REQ-008 Requests arriving in the current cycle are not candidates until registered into pending; grant latency from req pulse to valid is 2 cycles.
REQ-009 In PRESENT, code and valid SHALL hold stable until out_ready=1.
REQ-010 On handshake (valid & out_ready), if en=1 and pending!=0, SHALL grant the next line on the same edge and stay in PRESENT, for back-to-back throughput of one code per cycle; otherwise go to IDLE.
REQ-011 en=0 SHALL block new grants only; a presented code still completes its handshake.
REQ-012 Fixed priority (rr=0): highest set index of pending wins (bit 7 over bit 0).
REQ-013 Round-robin (rr=1): search descends from last granted index minus one, wrapping 0 to 7; the last-granted line has lowest priority.
REQ-014 SHALL keep a 3-bit last-granted register updated on every grant regardless of rr; a change of rr takes effect at the next grant.
REQ-015 code SHALL hold its last value while valid=0.

Reset
REQ-016 rst=1 at a clock edge SHALL force: state IDLE, valid=0, code=3'b000, pending=8'h00, dup=0, last-granted=3'b000, including mid-handshake; req in the reset cycle is discarded.
REQ-017 The first grant after reset with rr=1 SHALL search from index 7 downward.

Verification
REQ-018 Reset then req=8'h00 for 5 cycles -> valid=0, code=0, pending=8'h00, dup=0 throughout.
REQ-019 rr=0, en=1, out_ready=1, one-cycle req=8'b1000_0101 -> codes 7, 2, 0 on three consecutive cycles with valid=1, then valid=0 and pending=8'h00.
REQ-020 rr=0, out_ready=0, req=8'h10 -> code=4, valid=1 held 4 cycles; then out_ready=1 for 1 cycle -> valid=0 next cycle.
REQ-021 rr=1, pending held at 8'hFF by repeating req=8'hFF, out_ready=1 -> codes 7,6,5,4,3,2,1,0,7 cycle-by-cycle; dup pulses on each re-request of a still-pending line.
REQ-022 en=0 with req=8'h03 -> pending=8'h03, valid=0; en=1 -> code=1 then code=0.
REQ-023 Reset asserted while valid=1 and pending=8'h0C -> next cycle valid=0, code=0, pending=8'h00.
